seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Output-side counterpart to the board input debouncer: drives the 8-digit multiplexed seven-segment display from a 32-bit hex value plus per-digit masks. Time-multiplexes one digit at a time, with dead-time anti-ghosting, per-digit blinking and frame-coherent input snapshotting. Sits between top-level game/FSM logic and the board anode/segment pins.

Parameters:
SCAN_MAX, 17'd99_999, scan-counter terminal value; each digit slot lasts SCAN_MAX+1 clk cycles (1 ms at 100 MHz)
SCAN_WIDTH, 17, scan counter width
DEAD_CYCLES, 17'd2_000, cycles at the start of each slot with all anodes off; must be < SCAN_MAX
BLINK_FRAMES, 8'd62, frames per blink half-period (~0.5 s)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
data  input  32  hex nibbles; data[4i+3:4i] is the value for digit i (digit 0 rightmost)
dp_mask  input  8  bit i lights the decimal point of digit i
blank_mask  input  8  bit i forces digit i fully dark
blink_mask  input  8  bit i blanks digit i during the blink-off phase
an  output  8  digit enables, one-hot active-high, registered
seg  output  8  segments, active-high, registered; seg[0]=a..seg[6]=g, seg[7]=dp
frame_start  output  1  one-cycle pulse when digit index wraps 7->0

Behaviour:
- Reset (rst==0 at clk edge): an=0, seg=0, frame_start=0, scan_cnt=0, idx=0, blink_cnt=0, blink_phase=0, snapshot regs=0, primed=0.
- scan_cnt increments every cycle; at SCAN_MAX it wraps to 0 and asserts internal tick.
- On tick: idx <= idx+1 (3-bit, 7 wraps to 0). On the 7->0 wrap, frame_start=1 in the following cycle and the snapshot is reloaded.
- Snapshot: data/dp_mask/blank_mask/blink_mask captured into internal regs only at frame wrap, plus once in the first cycle after reset release (primed 0->1). Input changes mid-frame never alter the current frame.
- Blink: blink_cnt counts frames; at BLINK_FRAMES-1 it clears and blink_phase toggles. Phase 0 = visible.
- Digit i is dark if blank_mask[i] | (blink_mask[i] & blink_phase) (snapshot values).
- Output register, updated every cycle from current idx/scan_cnt (one-cycle latency):
  - scan_cnt < DEAD_CYCLES -> an=0, seg=0.
  - otherwise, digit dark -> an=0, seg=0.
  - otherwise an=1<<idx, seg={dp_mask[idx], hex_to_seg7(nibble idx)}.
- Hex encoding (seg[6:0]): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Never more than one an bit high; an is 0 for at least DEAD_CYCLES cycles around every idx change.
- Reset mid-frame: all state cleared next edge; display restarts at digit 0 with a fresh snapshot.

Optional Feature:
SEG7_LZ_BLANK_EN: when defined, leading-zero suppression on the snapshot: scanning from digit 7 down, each zero nibble is treated as dark until the first nonzero nibble; digit 0 is never suppressed; a digit whose dp_mask bit is set still shows its dp (segments a-g off). When undefined, all zero nibbles display as "0".

Decomposition:
- parameters.vh: segment bit-position defines, SEG7 hex glyph constants, default scan/blink timing constants.
- Sub-module hex_to_seg7 (combinational 4-bit -> 7-bit glyph ROM), instantiated once on the selected nibble.

Test Plan (SCAN_MAX=3, DEAD_CYCLES=1, BLINK_FRAMES=2):
- Reset held 3 cycles, data=32'h76543210 -> an=0, seg=0 throughout; after release, digit 0 slot shows an=8'h01, seg=8'h3F in cycles 2-4 of the slot.
- Full frame, data=32'hFEDCBA98, dp_mask=8'h01 -> sequence an=01..80 with seg=FF,6F,77,7C,39,5E,79,71; an=0 on the first cycle of every slot; frame_start pulses once per 32 cycles.
- Change data to 32'h11111111 mid-frame -> remaining slots of that frame show old glyphs; next frame shows seg=06 on every digit.
- blink_mask=8'h04 -> digit 2 visible 2 frames, dark 2 frames, repeating; other digits unaffected.
- blank_mask=8'hFF -> an=0, seg=0 for an entire frame; frame_start still pulses.
- With SEG7_LZ_BLANK_EN, data=32'h00000105 -> digits 7-3 dark, digit 2 seg=06, digit 1 seg=3F, digit 0 seg=6D; data=0 -> only digit 0 lit, seg=3F.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// hex glyphs and default scan/blink timing.
package seg7_scan_driver_pkg;

  localparam int NUM_DIGITS = 8;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam int          DEF_SCAN_WIDTH   = 17;
  localparam logic [16:0] DEF_SCAN_MAX     = 17'd99_999;
  localparam logic [16:0] DEF_DEAD_CYCLES  = 17'd2_000;
  localparam logic [7:0]  DEF_BLINK_FRAMES = 8'd62;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: hex value and per-digit masks in, anode/segment pins out.
interface seg7_scan_driver_if;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic [7:0]  blank_mask;
  logic [7:0]  blink_mask;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_start;

  modport master (
    output data, dp_mask, blank_mask, blink_mask,
    input  an, seg, frame_start
  );

  modport slave (
    input  data, dp_mask, blank_mask, blink_mask,
    output an, seg, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational 4-bit to seven-segment glyph ROM (seg[0]=a .. seg[6]=g).
module seg7_scan_driver_hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_0;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed seven-segment driver with dead-time, blinking and frame snapshots.
// Define SEG7_LZ_BLANK_EN to enable leading-zero suppression.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int                     SCAN_WIDTH   = DEF_SCAN_WIDTH,
  parameter logic [SCAN_WIDTH-1:0]  SCAN_MAX     = DEF_SCAN_MAX,
  parameter logic [SCAN_WIDTH-1:0]  DEAD_CYCLES  = DEF_DEAD_CYCLES,
  parameter logic [7:0]             BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  logic [SCAN_WIDTH-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  primed_q, primed_d;
  logic [31:0]           snap_data_q, snap_data_d;
  logic [7:0]            snap_dp_q, snap_dp_d;
  logic [7:0]            snap_blank_q, snap_blank_d;
  logic [7:0]            snap_blink_q, snap_blink_d;
  logic [7:0]            an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_start_q, frame_start_d;

  logic                  tick, wrap, load;
  logic                  dig_dark, dp_bit;
  logic [3:0]            cur_nibble;
  logic [6:0]            glyph, glyph_shown;
`ifdef SEG7_LZ_BLANK_EN
  logic [7:0]            lz_sup;
  logic                  zero_run;
`endif

  assign cur_nibble = snap_data_q[{idx_q, 2'b00} +: 4];

  seg7_scan_driver_hex_to_seg7 u_hex (
    .nibble (cur_nibble),
    .glyph  (glyph)
  );

  always_comb begin
    tick          = (scan_cnt_q == SCAN_MAX);
    wrap          = tick && (idx_q == 3'd7);
    scan_cnt_d    = tick ? '0 : scan_cnt_q + SCAN_WIDTH'(1);
    idx_d         = tick ? idx_q + 3'd1 : idx_q;
    frame_start_d = wrap;
    primed_d      = 1'b1;

    // Inputs are only sampled at frame boundaries so a frame never tears.
    load         = wrap || !primed_q;
    snap_data_d  = load ? bus.data       : snap_data_q;
    snap_dp_d    = load ? bus.dp_mask    : snap_dp_q;
    snap_blank_d = load ? bus.blank_mask : snap_blank_q;
    snap_blink_d = load ? bus.blink_mask : snap_blink_q;

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      if (blink_cnt_q == BLINK_FRAMES - 8'd1) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end

    dig_dark    = snap_blank_q[idx_q] | (snap_blink_q[idx_q] & blink_phase_q);
    dp_bit      = snap_dp_q[idx_q];
    glyph_shown = glyph;

`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    zero_run  = 1'b1;
    lz_sup    = '0;
    for (int i = 7; i >= 1; i--) begin
      zero_run  = zero_run & (snap_data_q[4*i +: 4] == 4'h0);
      lz_sup[i] = zero_run;
    end
    if (lz_sup[idx_q]) begin
      glyph_shown = '0;
      if (!dp_bit) dig_dark = 1'b1;
    end
`endif

    an_d  = '0;
    seg_d = '0;
    if ((scan_cnt_q >= DEAD_CYCLES) && !dig_dark) begin
      an_d                = 8'd1 << idx_q;
      seg_d[SEG_DP]       = dp_bit;
      seg_d[SEG_G:SEG_A]  = glyph_shown;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      primed_q      <= 1'b0;
      snap_data_q   <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '0;
      snap_blink_q  <= '0;
      an_q          <= '0;
      seg_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      primed_q      <= primed_d;
      snap_data_q   <= snap_data_d;
      snap_dp_q     <= snap_dp_d;
      snap_blank_q  <= snap_blank_d;
      snap_blink_q  <= snap_blink_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-cycle slot, 1 dead cycle and 2-frame blink.
// Expected leading-zero results follow SEG7_LZ_BLANK_EN when it is defined.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  seg7_scan_driver_if bus_if ();

  seg7_scan_driver #(
    .SCAN_WIDTH   (17),
    .SCAN_MAX     (17'd3),
    .DEAD_CYCLES  (17'd1),
    .BLINK_FRAMES (8'd2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered on the dead (first) output cycle of slot lo; leaves on the dead cycle after slot hi.
  task automatic check_part(input int fr, input int lo, input int hi,
                            input logic [63:0] segv, input logic [7:0] lit);
    logic [7:0] e_an, e_seg, e_fs;
    for (int s = lo; s <= hi; s++) begin
      check8($sformatf("f%0d s%0d dead an", fr, s), bus_if.an, 8'h00);
      check8($sformatf("f%0d s%0d dead seg", fr, s), bus_if.seg, 8'h00);
      check8($sformatf("f%0d s%0d dead fs", fr, s), {7'b0, bus_if.frame_start}, 8'h00);
      for (int j = 0; j < 3; j++) begin
        step();
        e_an  = lit[s] ? 8'(1 << s) : 8'h00;
        e_seg = lit[s] ? segv[8*s +: 8] : 8'h00;
        e_fs  = (s == 7 && j == 2) ? 8'h01 : 8'h00;
        check8($sformatf("f%0d s%0d c%0d an", fr, s, j), bus_if.an, e_an);
        check8($sformatf("f%0d s%0d c%0d seg", fr, s, j), bus_if.seg, e_seg);
        check8($sformatf("f%0d s%0d c%0d fs", fr, s, j), {7'b0, bus_if.frame_start}, e_fs);
      end
      step();
    end
  endtask

  initial begin
    rst                = 1'b0;
    bus_if.data        = 32'h7654_3210;
    bus_if.dp_mask     = 8'h00;
    bus_if.blank_mask  = 8'h00;
    bus_if.blink_mask  = 8'h00;

    for (int k = 0; k < 3; k++) begin
      step();
      check8($sformatf("rst%0d an", k), bus_if.an, 8'h00);
      check8($sformatf("rst%0d seg", k), bus_if.seg, 8'h00);
      check8($sformatf("rst%0d fs", k), {7'b0, bus_if.frame_start}, 8'h00);
    end

    rst = 1'b1;
    step();

    // Frame 0: 76543210; new inputs arrive mid-frame and must wait for the next frame.
    check_part(0, 0, 3, 64'h077D6D66_4F5B063F, 8'hFF);
    bus_if.data    = 32'hFEDC_BA98;
    bus_if.dp_mask = 8'h01;
    check_part(0, 4, 7, 64'h077D6D66_4F5B063F, 8'hFF);

    // Frame 1: FEDCBA98 with dp on digit 0.
    check_part(1, 0, 3, 64'h71795E39_7C776FFF, 8'hFF);
    bus_if.data       = 32'h1111_1111;
    bus_if.dp_mask    = 8'h00;
    bus_if.blink_mask = 8'h04;
    check_part(1, 4, 7, 64'h71795E39_7C776FFF, 8'hFF);

    // Frames 2-5: digit 2 dark in frames 2 and 3, visible in 4 and 5.
    check_part(2, 0, 7, 64'h06060606_06060606, 8'hFB);
    check_part(3, 0, 7, 64'h06060606_06060606, 8'hFB);
    check_part(4, 0, 7, 64'h06060606_06060606, 8'hFF);
    check_part(5, 0, 3, 64'h06060606_06060606, 8'hFF);
    bus_if.blank_mask = 8'hFF;
    bus_if.blink_mask = 8'h00;
    check_part(5, 4, 7, 64'h06060606_06060606, 8'hFF);

    // Frame 6: everything blanked, frame_start still pulses.
    check_part(6, 0, 3, 64'h06060606_06060606, 8'h00);
    bus_if.blank_mask = 8'h00;
    bus_if.data       = 32'h0000_0105;
    check_part(6, 4, 7, 64'h06060606_06060606, 8'h00);

`ifdef SEG7_LZ_BLANK_EN
    check_part(7, 0, 3, 64'h3F3F3F3F_3F063F6D, 8'h07);
    bus_if.data = 32'h0000_0000;
    check_part(7, 4, 7, 64'h3F3F3F3F_3F063F6D, 8'h07);
    check_part(8, 0, 1, 64'h3F3F3F3F_3F3F3F3F, 8'h01);
`else
    check_part(7, 0, 3, 64'h3F3F3F3F_3F063F6D, 8'hFF);
    bus_if.data = 32'h0000_0000;
    check_part(7, 4, 7, 64'h3F3F3F3F_3F063F6D, 8'hFF);
    check_part(8, 0, 1, 64'h3F3F3F3F_3F3F3F3F, 8'hFF);
`endif

    // Mid-frame reset: restart at digit 0 with a fresh snapshot.
    rst         = 1'b0;
    bus_if.data = 32'h89AB_CDEF;
    step();
    check8("midrst an", bus_if.an, 8'h00);
    check8("midrst seg", bus_if.seg, 8'h00);
    check8("midrst fs", {7'b0, bus_if.frame_start}, 8'h00);
    rst = 1'b1;
    step();
    check_part(9, 0, 1, 64'h00000000_00007971, 8'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
